// File: rtl/trans_collector_pkg.sv
// rtl/trans_collector_pkg.sv - shared constants and FSM encoding for the toggle collector
package trans_collector_pkg;

  // Defaults shared with the counter memory and the readout logic
  localparam int NUM_NETS_DEF = 8;
  localparam int ADDR_W_DEF   = 3;
  localparam int CNT_W_DEF    = 32;
  localparam int PEND_W_DEF   = 4;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_SCAN  = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_IDLE  = 3'd4
  } state_t;

endpackage

// File: rtl/trans_pend_cell.sv
// rtl/trans_pend_cell.sv - one saturating pending-toggle counter
module trans_pend_cell
  import trans_collector_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              snap_clr,
  output logic [PEND_W-1:0] cnt,
  output logic              lost
);

  logic sat;

  assign sat = &cnt;
  // A snapshot clear reloads with the coincident toggle, so only a toggle at saturation is lost
  assign lost = inc & sat & ~snap_clr;

  // Counter: clear-on-snapshot keeps the same-cycle toggle, otherwise saturating increment
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (snap_clr) begin
      cnt <= PEND_W'(inc);
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/trans_collector.sv
// rtl/trans_collector.sv - counts net toggles into pending counters and folds them into counter memory
module trans_collector
  import trans_collector_pkg::*;
#(
  parameter int NUM_NETS = NUM_NETS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PEND_W   = PEND_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_NETS-1:0] net_in,
  input  logic                hold,
  output logic                idle,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [CNT_W-1:0]    mem_wdata,
  input  logic [CNT_W-1:0]    mem_rdata,
  output logic                ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NETS - 1);
  localparam logic [ADDR_W:0]   NETS_EXT  = (ADDR_W + 1)'(NUM_NETS);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_d;
  logic [ADDR_W-1:0]   ptr, ptr_d;
  logic [ADDR_W-1:0]   idx, idx_d;
  logic [PEND_W-1:0]   snap;
  logic [NUM_NETS-1:0] prev;
  logic                prev_valid;
  logic [NUM_NETS-1:0] toggle;
  logic [NUM_NETS-1:0] busy;
  logic [NUM_NETS-1:0] snap_clr;
  logic [NUM_NETS-1:0] lost;
  logic [PEND_W-1:0]   pend [NUM_NETS];
  logic                found;
  logic [ADDR_W-1:0]   sel;
  logic [ADDR_W:0]     probe;
  logic                rd_d, wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [CNT_W-1:0]    wdata_d;

  // The first cycle after reset only primes prev, so a stale prev never looks like a toggle
  assign toggle = prev_valid ? (net_in ^ prev) : '0;
  assign idle   = (state == ST_IDLE);

  for (genvar i = 0; i < NUM_NETS; i++) begin : g_pend
    trans_pend_cell #(.PEND_W(PEND_W)) u_cell (
      .clk      (CLK),
      .reset    (RESET),
      .inc      (toggle[i]),
      .snap_clr (snap_clr[i]),
      .cnt      (pend[i]),
      .lost     (lost[i])
    );
    assign busy[i]     = |pend[i];
    assign snap_clr[i] = (state == ST_RD) && (idx == ADDR_W'(i));
  end

  // Round-robin search: lowest offset from ptr whose pending counter is non-zero
  always_comb begin
    found = 1'b0;
    sel   = '0;
    probe = '0;
    for (int k = NUM_NETS - 1; k >= 0; k--) begin
      probe = {1'b0, ptr} + (ADDR_W + 1)'(k);
      if (probe >= NETS_EXT) begin
        probe = probe - NETS_EXT;
      end
      if (busy[probe[ADDR_W-1:0]]) begin
        found = 1'b1;
        sel   = probe[ADDR_W-1:0];
      end
    end
  end

  // Next-state and next memory-port values; the port registers load these on the edge
  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    ptr_d      = ptr;
    idx_d      = idx;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    case (state)
      ST_CLEAR: begin
        wr_d    = 1'b1;
        addr_d  = clr_addr;
        wdata_d = '0;
        if (clr_addr == LAST_ADDR) begin
          state_d = ST_SCAN;
        end else begin
          clr_addr_d = clr_addr + 1'b1;
        end
      end
      ST_SCAN: begin
        if (hold) begin
          state_d = ST_IDLE;
        end else if (found) begin
          state_d = ST_RD;
          idx_d   = sel;
          rd_d    = 1'b1;
          addr_d  = sel;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        wr_d    = 1'b1;
        addr_d  = idx;
        wdata_d = mem_rdata + CNT_W'(snap);
        ptr_d   = (idx == LAST_ADDR) ? '0 : idx + 1'b1;
        state_d = ST_SCAN;
      end
      ST_IDLE: begin
        if (!hold) begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // FSM and bookkeeping registers; reset abandons any RMW before its write is issued
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      ptr        <= '0;
      idx        <= '0;
      snap       <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_d;
      clr_addr   <= clr_addr_d;
      ptr        <= ptr_d;
      idx        <= idx_d;
      prev       <= net_in;
      prev_valid <= 1'b1;
      ovf        <= ovf | (|lost);
      if (state == ST_RD) begin
        snap <= pend[idx];
      end
    end
  end

  // Registered memory port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_rd    <= rd_d;
      mem_wr    <= wr_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_trans_collector.sv
// tb/tb_trans_collector.sv - self-checking bench for trans_collector
module tb_trans_collector;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  net_in = '0;
  logic        hold = 1'b0;
  logic        idle;
  logic [2:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  trans_collector dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .net_in    (net_in),
    .hold      (hold),
    .idle      (idle),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ovf       (ovf)
  );

  always #5 CLK = ~CLK;

  // Counter memory model with write history
  logic [31:0] mem [8];
  logic [2:0]  wr_addr_hist [256];
  logic [31:0] wr_data_hist [256];
  int          wr_count = 0;
  int          rd_count = 0;
  int          both_count = 0;
  logic        preload_en = 1'b0;
  logic [2:0]  preload_addr = '0;
  logic [31:0] preload_val = '0;

  always @(posedge CLK) begin
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_hist[wr_count % 256] <= mem_addr;
      wr_data_hist[wr_count % 256] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_count  <= rd_count + 1;
    end
    if (mem_rd && mem_wr) both_count <= both_count + 1;
    if (preload_en) mem[preload_addr] <= preload_val;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET  = 1'b1;
    hold   = 1'b0;
    net_in = '0;
    repeat (2) tick();
    RESET = 1'b0;
  endtask

  task automatic check_clear_writes(input string tag, input int start);
    check({tag, "_wr_count"}, 32'(wr_count - start), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_addr"}, 32'(wr_addr_hist[(start + i) % 256]), 32'(i));
      check({tag, "_data"}, wr_data_hist[(start + i) % 256], 32'd0);
    end
  endtask

  typedef struct {
    logic [7:0]  mask;
    int          ntog;
    int          gap;
    bit          use_hold;
    int          pre_addr;
    logic [31:0] pre_val;
    logic [31:0] exp_word;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int wc0;
    int st0;
    int seen;
    int cnt [8];
    int hold_left;

    vecs[0] = '{8'h08, 5,  2, 1'b0, -1, 32'h0,        32'd5,  1'b0};
    vecs[1] = '{8'h81, 40, 1, 1'b0, -1, 32'h0,        32'd40, 1'b0};
    vecs[2] = '{8'h04, 2,  2, 1'b0, 2,  32'hFFFFFFFF, 32'd1,  1'b0};
    vecs[3] = '{8'h20, 20, 1, 1'b1, -1, 32'h0,        32'd15, 1'b1};
    vecs[4] = '{8'h55, 3,  4, 1'b0, -1, 32'h0,        32'd3,  1'b0};

    // Reset state and the initial clear sweep with static nets
    RESET = 1'b1;
    repeat (2) tick();
    check("rst_idle",  32'(idle), 32'd0);
    check("rst_rd",    32'(mem_rd), 32'd0);
    check("rst_wr",    32'(mem_wr), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    wc0 = wr_count;
    st0 = rd_count;
    RESET = 1'b0;
    repeat (20) tick();
    check_clear_writes("clear", wc0);
    check("clear_reads", 32'(rd_count - st0), 32'd0);
    for (int i = 0; i < 8; i++) check("clear_mem", mem[i], 32'd0);

    // Directed table
    foreach (vecs[v]) begin
      do_reset();
      repeat (12) tick();
      if (vecs[v].pre_addr >= 0) begin
        preload_addr = 3'(vecs[v].pre_addr);
        preload_val  = vecs[v].pre_val;
        preload_en   = 1'b1;
        tick();
        preload_en   = 1'b0;
      end
      if (vecs[v].use_hold) begin
        hold = 1'b1;
        for (int c = 0; c < 20 && !idle; c++) tick();
        check("hold_idle_enter", 32'(idle), 32'd1);
      end
      st0 = wr_count + rd_count;
      for (int n = 0; n < vecs[v].ntog; n++) begin
        net_in = net_in ^ vecs[v].mask;
        repeat (vecs[v].gap) tick();
      end
      if (vecs[v].use_hold) begin
        check("hold_idle",    32'(idle), 32'd1);
        check("hold_strobes", 32'(wr_count + rd_count - st0), 32'd0);
        check("hold_ovf",     32'(ovf), 32'(vecs[v].exp_ovf));
        hold = 1'b0;
      end
      repeat (60) tick();
      for (int i = 0; i < 8; i++) begin
        check($sformatf("vec%0d_mem%0d", v, i), mem[i],
              vecs[v].mask[i] ? vecs[v].exp_word : 32'd0);
      end
      check($sformatf("vec%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
    end

    // Reset during the read phase of an RMW: no write, clear sweep restarts
    do_reset();
    repeat (12) tick();
    net_in[1] = ~net_in[1];
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_rd) begin
        seen = 1;
        break;
      end
    end
    check("rmw_rd_seen", 32'(seen), 32'd1);
    wc0 = wr_count;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (20) tick();
    check_clear_writes("rmw_rst", wc0);
    for (int i = 0; i < 8; i++) check("rmw_rst_mem", mem[i], 32'd0);

    // Random toggles and short hold bursts against a per-net toggle tally
    do_reset();
    repeat (12) tick();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    hold_left = 0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(7) == 0) begin
          net_in[b] = ~net_in[b];
          cnt[b]++;
        end
      end
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(49) == 0) hold_left = int'($urandom_range(4, 1));
      hold = (hold_left > 0);
      tick();
    end
    hold = 1'b0;
    repeat (80) tick();
    for (int i = 0; i < 8; i++) check($sformatf("rand_mem%0d", i), mem[i], 32'(cnt[i]));
    check("rand_ovf", 32'(ovf), 32'd0);
    check("rd_wr_overlap", 32'(both_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trans_collector.md
TRANS_COLLECTOR -- requirements
Module: trans_collector

Interface
REQ-001 Parameter NUM_NETS, default 8: number of monitored nets, one counter word per net.
REQ-002 Parameter ADDR_W, default 3: counter memory address width, 2^ADDR_W >= NUM_NETS.
REQ-003 Parameter CNT_W, default 32: counter word width.
REQ-004 Parameter PEND_W, default 4: per-net pending toggle counter width.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 net_in  in  NUM_NETS  monitored gate outputs; bit i maps to counter address i.
REQ-008 hold  in  1  request to park the block so an external reader may own the counter memory.
REQ-009 idle  out  1  high when parked; memory port is then released.
REQ-010 mem_addr  out  ADDR_W  counter memory address.
REQ-011 mem_rd  out  1  read strobe; mem_rdata valid exactly one cycle later.
REQ-012 mem_wr  out  1  write strobe; mem_wdata written at mem_addr on the same edge.
REQ-013 mem_wdata  out  CNT_W  write data.
REQ-014 mem_rdata  in  CNT_W  read data from the counter memory.
REQ-015 ovf  out  1  sticky flag: at least one toggle was lost to pending saturation.

Function
REQ-016 The block SHALL register net_in into prev each cycle; toggle[i] = net_in[i] XOR prev[i].
REQ-017 The first cycle after reset SHALL load prev without counting toggles (prev_valid flag).
REQ-018 Each toggle[i] SHALL increment pend[i] on the same edge, saturating at 2^PEND_W-1; a toggle arriving at saturation SHALL set ovf.
REQ-019 Toggles SHALL keep accumulating in pend[] in every state, including CLEAR and IDLE.
REQ-020 FSM states SHALL be CLEAR, SCAN, RD, WR, IDLE.
REQ-021 CLEAR: one write per cycle, mem_wr=1, mem_wdata=0, addresses 0..NUM_NETS-1 ascending; SHALL then go to SCAN.
REQ-022 SCAN: if hold=1, go to IDLE; otherwise select the first i with pend[i]!=0, searching round-robin from ptr; go to RD with idx=i. If none is found, stay in SCAN.
REQ-023 RD: mem_rd=1, mem_addr=idx. On the same edge, snap<=pend[idx]. pend[idx] SHALL be set to toggle[idx] (0 or 1), so a simultaneous toggle is never lost.
REQ-024 WR: mem_wr=1, mem_addr=idx, mem_wdata=mem_rdata+snap, taken modulo 2^CNT_W. ptr SHALL advance to idx+1, wrapping at NUM_NETS-1 to 0. The next state SHALL be SCAN.
REQ-025 Each RMW SHALL take exactly 3 cycles: SCAN, RD, WR.
REQ-026 hold SHALL NOT abort an RMW in progress; it is honoured only in SCAN.
REQ-027 IDLE: idle=1, mem_rd=mem_wr=0. The block SHALL return to SCAN on the first cycle with hold=0.
REQ-028 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-029 mem_addr, mem_rd, mem_wr and mem_wdata SHALL be registered outputs.

Reset
REQ-030 RESET=1 SHALL force state=CLEAR, clear-address=0, ptr=0, pend[]=0, snap=0, prev_valid=0, ovf=0, idle=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-031 RESET asserted mid-RMW SHALL abandon the RMW with no write, then restart CLEAR.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the default NUM_NETS, ADDR_W, CNT_W and PEND_W constants, which are shared with the counter memory and the readout logic.
REQ-033 A single sub-module, trans_pend_cell, SHALL implement one saturating pending counter with increment, snapshot-clear and overflow output, instantiated NUM_NETS times.

Verification
REQ-034 Reset, all nets static for 20 cycles -> 8 zero writes to addresses 0..7, then no memory traffic; counter memory all 0.
REQ-035 Toggle net 3 five times, 2 cycles apart -> memory[3] ends at 5 and every other word stays 0.
REQ-036 Toggle nets 0 and 7 together every cycle for 40 cycles -> memory[0]+pend[0] = memory[7]+pend[7] = 40 at end; ovf=0.
REQ-037 Preload memory[2]=0xFFFFFFFF, toggle net 2 twice -> memory[2]=0x00000001.
REQ-038 Hold net 5 toggling every cycle with hold=1 for 20 cycles -> idle=1, no memory strobes, ovf=1; after hold=0, memory[5]=15.
REQ-039 Assert RESET in the RD cycle of an RMW -> no write issued, CLEAR rewrites all 8 words to 0.
